// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Front-end controller for the 3-bit CPU. It accepts a program as a stream of
// 9-bit instruction words over a valid/ready handshake, writes them into the
// CPU RAM through the CPU's external write port, and holds the CPU in reset
// while loading. Once armed it drives PC_Enable for free-running execution
// (bounded by a cycle budget) or for single steps.
//
// Parameters
//   DEPTH    number of CPU RAM rows (address width = clog2(DEPTH))
//   MAX_RUN  number of enabled CPU cycles before RUN falls back to ARMED
//
// Ports
//   clk                system clock, shared with the CPU
//   reset              asynchronous, active-low reset
//   load               pulse: start or restart a program load
//   in_valid/in_ready  instruction word handshake
//   in_data            instruction word
//   in_last            marks in_data as the final word of the program
//   run / step / stop  execution control pulses
//   RAM_Write_*        CPU RAM external write port
//   cpu_reset          active-high reset hold to the CPU
//   PC_Enable          CPU clock-gate enable, changes on falling clk only
//   loaded             words written by the last load (0..DEPTH)
//   busy               high while loading, running or stepping
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int DEPTH   = 8,
  parameter int MAX_RUN = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic                       in_valid,
  input  logic [8:0]                 in_data,
  input  logic                       in_last,
  output logic                       in_ready,
  input  logic                       run,
  input  logic                       step,
  input  logic                       stop,
  output logic [8:0]                 RAM_Write_Data,
  output logic [$clog2(DEPTH)-1:0]   RAM_Write_Address,
  output logic                       RAM_Write_Enable,
  output logic                       cpu_reset,
  output logic                       PC_Enable,
  output logic [$clog2(DEPTH+1)-1:0] loaded,
  output logic                       busy
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
  localparam logic [7:0]    RUN_LAST = 8'(MAX_RUN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARMED,
    S_RUN,
    S_STEP
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] run_cnt;

  logic accept;
  logic last_word;
  logic start_run;

  logic in_ready_d;
  logic cpu_reset_d;
  logic busy_d;
  logic pc_en_d;
  logic pc_en_q;

  // A word is taken only while the loader is ready; a simultaneous load
  // command restarts the load and drops that word.
  assign accept    = in_valid && in_ready && !load;
  // The word being accepted is the final one if it is flagged or if it
  // fills the last RAM row.
  assign last_word = in_last || (loaded == LAST_IDX);
  assign start_run = (state == S_ARMED) && (next_state == S_RUN);

  // ---------------------------------------------------------------------------
  // State register and registered FSM outputs
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking (<=) assignments so that all
  // flops sample the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      pc_en_q   <= 1'b0;
    end else begin
      state     <= next_state;
      in_ready  <= in_ready_d;
      cpu_reset <= cpu_reset_d;
      busy      <= busy_d;
      pc_en_q   <= pc_en_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Command priority: load > stop > step > run.
  // ---------------------------------------------------------------------------
  // NOTE: next_state gets a default before the case so that no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (load) next_state = S_LOAD;
      end
      S_LOAD: begin
        if (load)                        next_state = S_LOAD;
        else if (accept && last_word)    next_state = S_ARMED;
      end
      S_ARMED: begin
        if (load)      next_state = S_LOAD;
        else if (step) next_state = S_STEP;
        else if (run)  next_state = S_RUN;
      end
      S_RUN: begin
        if (load)                      next_state = S_LOAD;
        else if (stop)                 next_state = S_ARMED;
        else if (run_cnt == RUN_LAST)  next_state = S_ARMED;
      end
      S_STEP: begin
        if (load) next_state = S_LOAD;
        else      next_state = S_ARMED;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode, registered above so every output changes on posedge only.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready_d  = (next_state == S_LOAD);
    cpu_reset_d = (next_state == S_IDLE) || (next_state == S_LOAD);
    busy_d      = (next_state == S_LOAD) || (next_state == S_RUN) ||
                  (next_state == S_STEP);
    // The enable is computed from the state the CPU is already in, so it lags
    // the state by one posedge. A load or stop kills it at once, so an abort
    // never hands the CPU an extra clock.
    pc_en_d     = ((state == S_RUN)  && !load && !stop) ||
                  ((state == S_STEP) && !load);
  end

  // ---------------------------------------------------------------------------
  // Load datapath and run budget counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RAM_Write_Enable  <= 1'b0;
      RAM_Write_Data    <= '0;
      RAM_Write_Address <= '0;
      loaded            <= '0;
      run_cnt           <= '0;
    end else begin
      // One-cycle write strobe, one cycle after the accept.
      RAM_Write_Enable <= accept;
      if (accept) begin
        RAM_Write_Data    <= in_data;
        RAM_Write_Address <= loaded[AW-1:0];
      end

      // The word count doubles as the write address of the next word.
      if (load)        loaded <= '0;
      else if (accept) loaded <= loaded + 1'b1;

      if (start_run)             run_cnt <= '0;
      else if (state == S_RUN)   run_cnt <= run_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Retime the enable onto the falling edge: it is then constant through every
  // high phase of clk, so the CPU's AND-gated clock cannot glitch.
  // ---------------------------------------------------------------------------
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) PC_Enable <= 1'b0;
    else        PC_Enable <= pc_en_q;
  end

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Self-checking bench for program_loader (DEPTH=8, MAX_RUN=5). Stimulus pushes
// the RAM writes it expects into a scoreboard queue; a negedge monitor pops
// and compares whenever the DUT strobes RAM_Write_Enable. A posedge monitor
// plays the CPU: it counts gated clock edges (PC_Enable high at a rising clk).
// -----------------------------------------------------------------------------
module tb_program_loader;

  localparam int DEPTH   = 8;
  localparam int MAX_RUN = 5;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       load     = 1'b0;
  logic       in_valid = 1'b0;
  logic [8:0] in_data  = '0;
  logic       in_last  = 1'b0;
  logic       run      = 1'b0;
  logic       step     = 1'b0;
  logic       stop     = 1'b0;

  logic       in_ready;
  logic [8:0] RAM_Write_Data;
  logic [2:0] RAM_Write_Address;
  logic       RAM_Write_Enable;
  logic       cpu_reset;
  logic       PC_Enable;
  logic [3:0] loaded;
  logic       busy;

  program_loader #(.DEPTH(DEPTH), .MAX_RUN(MAX_RUN)) dut (
    .clk               (clk),
    .reset             (reset),
    .load              (load),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_last           (in_last),
    .in_ready          (in_ready),
    .run               (run),
    .step              (step),
    .stop              (stop),
    .RAM_Write_Data    (RAM_Write_Data),
    .RAM_Write_Address (RAM_Write_Address),
    .RAM_Write_Enable  (RAM_Write_Enable),
    .cpu_reset         (cpu_reset),
    .PC_Enable         (PC_Enable),
    .loaded            (loaded),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] addr;
    logic [8:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [8:0] ram_exp  [DEPTH];
  logic [8:0] ram_seen [DEPTH];

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int cpu_edges = 0;
  int last_edge = -1;

  // Reference model of the load: words accepted so far and whether the
  // loader should still be taking words.
  int m_count = 0;
  bit m_open  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  // CPU side: one CPU clock edge per rising clk while PC_Enable is high.
  always @(posedge clk) begin
    cyc++;
    if (PC_Enable === 1'b1) begin
      cpu_edges++;
      last_edge = cyc;
    end
  end

  // RAM write scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b1 && RAM_Write_Enable === 1'b1) begin
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 32'(RAM_Write_Address), 32'(e.addr));
        check("write_data", 32'(RAM_Write_Data), 32'(e.data));
      end
      ram_seen[RAM_Write_Address] = RAM_Write_Data;
    end
  end

  // PC_Enable may only move while clk is low.
  always @(PC_Enable) begin
    if (reset === 1'b1) check("pc_enable_moves_in_low_phase", 32'(clk), 32'd0);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel: 0 load, 1 run, 2 step, 3 stop. The pulse is sampled by the next posedge.
  task automatic pulse(input int sel);
    case (sel)
      0: load = 1'b1;
      1: run  = 1'b1;
      2: step = 1'b1;
      default: stop = 1'b1;
    endcase
    tick();
    load = 1'b0;
    run  = 1'b0;
    step = 1'b0;
    stop = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_in_ready",  32'(in_ready),          32'd0);
    check("rst_we",        32'(RAM_Write_Enable),  32'd0);
    check("rst_wdata",     32'(RAM_Write_Data),    32'd0);
    check("rst_waddr",     32'(RAM_Write_Address), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset),         32'd1);
    check("rst_pc_enable", 32'(PC_Enable),         32'd0);
    check("rst_loaded",    32'(loaded),            32'd0);
    check("rst_busy",      32'(busy),              32'd0);
    tick();
    tick();
    reset   = 1'b1;
    m_open  = 1'b0;
    m_count = 0;
  endtask

  task automatic start_load();
    pulse(0);
    m_open  = 1'b1;
    m_count = 0;
    check("load_busy",      32'(busy),      32'd1);
    check("load_cpu_reset", 32'(cpu_reset), 32'd1);
    check("load_loaded",    32'(loaded),    32'd0);
  endtask

  // mode 0: in_valid every slot, 1: alternating, 2: random (random in_last too).
  // base >= 0 gives data base+index, otherwise random data.
  task automatic send(input int n, input int mode, input int last_at, input int base);
    for (int i = 0; i < n; i++) begin
      logic       v;
      logic       l;
      logic [8:0] d;
      check("in_ready", 32'(in_ready), 32'(m_open));
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (i % 2 == 0);
      else                v = 1'($urandom_range(0, 1));
      if (mode == 2) l = ($urandom_range(0, 5) == 0);
      else           l = (i == last_at);
      if (base >= 0) d = 9'(base + m_count);
      else           d = 9'($urandom_range(0, 511));
      in_valid = v;
      in_last  = l;
      in_data  = d;
      tick();
      if (v && m_open) begin
        wr_t e;
        e.addr = 3'(m_count);
        e.data = d;
        exp_q.push_back(e);
        ram_exp[m_count] = d;
        m_count++;
        if (l || m_count == DEPTH) m_open = 1'b0;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic post_load_checks();
    tick();
    tick();
    check("post_loaded",    32'(loaded),    32'(m_count));
    check("post_in_ready",  32'(in_ready),  32'(m_open));
    check("post_cpu_reset", 32'(cpu_reset), 32'(m_open));
    check("post_busy",      32'(busy),      32'(m_open));
    check("post_pc_enable", 32'(PC_Enable), 32'd0);
  endtask

  // Enabled CPU cycles for a run ended by a stop (or load) command sampled
  // `gap` cycles after the run command: every cycle strictly between the two
  // commands, capped by the budget.
  function automatic int exp_run_edges(input int gap);
    return (gap - 1 < MAX_RUN) ? gap - 1 : MAX_RUN;
  endfunction

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int e0;
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      ram_exp[i]  = '0;
      ram_seen[i] = '0;
    end
    #2;
    do_reset();

    // run/step in IDLE are ignored.
    pulse(1);
    pulse(2);
    tick();
    tick();
    check("idle_busy",      32'(busy),      32'd0);
    check("idle_cpu_reset", 32'(cpu_reset), 32'd1);
    check("idle_edges",     32'(cpu_edges), 32'd0);

    // Eight back-to-back words fill the RAM.
    start_load();
    send(8, 0, -1, 'h101);
    post_load_checks();

    // Three words, in_last on the third; valid keeps toggling in afterwards.
    start_load();
    e0 = cpu_edges;
    pulse(1);
    check("load_ignores_run_busy", 32'(busy),      32'd1);
    check("load_ignores_run_rst",  32'(cpu_reset), 32'd1);
    send(6, 0, 2, -1);
    post_load_checks();
    check("load_no_edges", 32'(cpu_edges - e0), 32'd0);

    // Throttled handshake, ends by filling all rows.
    start_load();
    send(16, 1, -1, -1);
    post_load_checks();

    // Three single steps: each gives one CPU edge two cycles after the command.
    e0 = cpu_edges;
    for (int k = 0; k < 3; k++) begin
      pulse(2);
      n = cyc;
      check("step_busy", 32'(busy), 32'd1);
      repeat (4) tick();
      check("step_edge_cycle", 32'(last_edge), 32'(n + 2));
    end
    check("step_edge_count", 32'(cpu_edges - e0), 32'd3);
    check("step_armed_busy", 32'(busy), 32'd0);

    // Run to the budget.
    e0 = cpu_edges;
    pulse(1);
    check("run_busy", 32'(busy), 32'd1);
    repeat (10) tick();
    check("run_budget_edges", 32'(cpu_edges - e0), 32'(exp_run_edges(1000)));
    check("run_budget_armed", 32'(busy), 32'd0);
    check("run_budget_pc_off", 32'(PC_Enable), 32'd0);

    // Stop after two enabled cycles, then a few random stop distances.
    for (int t = 0; t < 5; t++) begin
      int gap;
      gap = (t == 0) ? 3 : int'($urandom_range(1, 7));
      e0 = cpu_edges;
      pulse(1);
      repeat (gap - 1) tick();
      pulse(3);
      repeat (8) tick();
      check($sformatf("run_stop_gap%0d_edges", gap), 32'(cpu_edges - e0), 32'(exp_run_edges(gap)));
      check("run_stop_armed", 32'(busy), 32'd0);
    end

    // load during RUN aborts into a fresh load at address 0.
    e0 = cpu_edges;
    pulse(1);
    tick();
    tick();
    start_load();
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    #1;
    check("abort_pc_off", 32'(PC_Enable), 32'd0);
    send(2, 0, 1, -1);
    post_load_checks();
    check("abort_edges", 32'(cpu_edges - e0), 32'(exp_run_edges(3)));

    // Random handshake and random in_last.
    start_load();
    send(20, 2, -1, -1);
    post_load_checks();

    // Reset in the middle of a load: written rows stay in the CPU RAM.
    start_load();
    send(3, 0, -1, -1);
    tick();
    do_reset();
    tick();
    check("after_mid_reset_cpu_reset", 32'(cpu_reset), 32'd1);

    repeat (3) tick();
    check("write_queue_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("ram_row%0d", i), 32'(ram_seen[i]), 32'(ram_exp[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
